// File: rtl/control_sequencer_if.sv
// Bus bundle between control_sequencer and its ROM / datapath / data-memory neighbours.
// The irq line exists only when CU_IRQ_EN is defined.
interface control_sequencer_if #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned INSTR_W = 16
);
  // Inputs to the sequencer
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [15:0]        A_bus;
  logic               V;
  logic               C;
  logic               N;
  logic               Z;
  logic               mem_ready;
`ifdef CU_IRQ_EN
  logic               irq;
`endif

  // Outputs from the sequencer
  logic [PC_W-1:0]    PC;
  logic [REG_AW-1:0]  DR;
  logic [REG_AW-1:0]  SA;
  logic [REG_AW-1:0]  SB;
  logic [3:0]         FS;
  logic               MB;
  logic               MD;
  logic               RW;
  logic               MM;
  logic               MW;
  logic               IL;
  logic               halted;

  // Sequencer side
  modport master (
`ifdef CU_IRQ_EN
    input  irq,
`endif
    input  instruction, instr_valid, A_bus, V, C, N, Z, mem_ready,
    output PC, DR, SA, SB, FS, MB, MD, RW, MM, MW, IL, halted
  );

  // ROM / datapath / memory side
  modport slave (
`ifdef CU_IRQ_EN
    output irq,
`endif
    output instruction, instr_valid, A_bus, V, C, N, Z, mem_ready,
    input  PC, DR, SA, SB, FS, MB, MD, RW, MM, MW, IL, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// FETCH/EXEC/HALT control sequencer for the 16-bit teaching CPU.
// Holds PC and IR, decodes the IR opcode into the datapath control word.
// Optional feature macro: CU_IRQ_EN (interrupt vectoring, epc and RETI).
// PC_W must not exceed 16 (jump targets come from the 16-bit A_bus).
module control_sequencer #(
  parameter int unsigned     PC_W    = 6,
  parameter int unsigned     REG_AW  = 4,
  parameter int unsigned     INSTR_W = 16,
  parameter logic [PC_W-1:0] IRQ_VEC = '0
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  localparam logic [3:0] OpAluImm = 4'h9;
  localparam logic [3:0] OpLd     = 4'hA;
  localparam logic [3:0] OpSt     = 4'hB;
  localparam logic [3:0] OpBrz    = 4'hC;
  localparam logic [3:0] OpBrn    = 4'hD;
  localparam logic [3:0] OpJmp    = 4'hE;
  localparam logic [3:0] OpHalt   = 4'hF;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
`ifdef CU_IRQ_EN
  logic [PC_W-1:0]    epc_q, epc_d;
  logic               mask_q, mask_d;
  logic               is_reti;
`endif

  logic [3:0]          op;
  logic [REG_AW-1:0]   dr, sa, sb;
  logic [PC_W-1:0]     pc_inc, br_target;
  logic [2*REG_AW-1:0] br_off;
  logic                exec_done;

  assign op = ir_q[INSTR_W-1 -: 4];
  assign dr = ir_q[INSTR_W-5 -: REG_AW];
  assign sa = ir_q[INSTR_W-5-REG_AW -: REG_AW];
  assign sb = ir_q[INSTR_W-5-2*REG_AW -: REG_AW];

  assign pc_inc    = pc_q + PC_W'(1);
  assign br_off    = {dr, sb};
  // Sign-extend (or truncate) the offset to PC width; wrap is modulo 2^PC_W.
  assign br_target = pc_inc + PC_W'(signed'(br_off));
  // LD/ST stall in EXEC until memory answers; everything else finishes in one cycle.
  assign exec_done = !((op == OpLd) || (op == OpSt)) || bus.mem_ready;

`ifdef CU_IRQ_EN
  assign is_reti = (dr == '1);
`else
  // Flags V/C, spare IR bits, upper A_bus bits and IRQ_VEC are not consumed here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.V, bus.C, bus.A_bus, ir_q, IRQ_VEC};
`endif
`ifdef CU_IRQ_EN
  logic unused_inputs;
  assign unused_inputs = ^{bus.V, bus.C, bus.A_bus, ir_q};
`endif

  // State, PC, IR (and epc/mask) registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
`ifdef CU_IRQ_EN
      epc_q   <= '0;
      mask_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef CU_IRQ_EN
      epc_q   <= epc_d;
      mask_q  <= mask_d;
`endif
    end
  end

  // Next-state, PC and IR update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef CU_IRQ_EN
    epc_d   = epc_q;
    mask_d  = mask_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          state_d = StFetch;
          unique case (op)
            OpBrz:   pc_d = bus.Z ? br_target : pc_inc;
            OpBrn:   pc_d = bus.N ? br_target : pc_inc;
            OpJmp:   pc_d = bus.A_bus[PC_W-1:0];
            OpHalt: begin
`ifdef CU_IRQ_EN
              if (is_reti) begin
                pc_d   = epc_q;
                mask_d = 1'b0;
              end else begin
                state_d = StHalt;
              end
`else
              // PC stays on the HALT instruction.
              state_d = StHalt;
`endif
            end
            default: pc_d = pc_inc;
          endcase
`ifdef CU_IRQ_EN
          // Interrupt overrides any branch/jump target; a HALT would resume after itself.
          if (bus.irq && !mask_q) begin
            epc_d   = (state_d == StHalt) ? pc_inc : pc_d;
            pc_d    = IRQ_VEC;
            mask_d  = 1'b1;
            state_d = StFetch;
          end
`endif
        end
      end
      StHalt: begin
`ifdef CU_IRQ_EN
        if (bus.irq && !mask_q) begin
          epc_d   = pc_inc;
          pc_d    = IRQ_VEC;
          mask_d  = 1'b1;
          state_d = StFetch;
        end
`endif
      end
      default: state_d = StFetch;
    endcase
  end

  // Control word decode from state and IR opcode.
  always_comb begin
    bus.FS     = 4'h0;
    bus.MB     = 1'b0;
    bus.MD     = 1'b0;
    bus.RW     = 1'b0;
    bus.MM     = 1'b0;
    bus.MW     = 1'b0;
    bus.IL     = 1'b0;
    bus.halted = 1'b0;
    unique case (state_q)
      StFetch: bus.IL = 1'b1;
      StExec: begin
        unique case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            bus.FS = op;
            bus.RW = 1'b1;
          end
          OpAluImm: begin
            bus.FS = 4'h2;
            bus.MB = 1'b1;
            bus.RW = 1'b1;
          end
          OpLd: begin
            bus.MM = 1'b1;
            bus.MD = 1'b1;
            bus.RW = 1'b1;
          end
          OpSt: begin
            bus.MM = 1'b1;
            bus.MW = 1'b1;
          end
          default: ;
        endcase
      end
      StHalt:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.PC = pc_q;
  assign bus.DR = dr;
  assign bus.SA = sa;
  assign bus.SB = sb;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default build, PC_W=6, REG_AW=4, INSTR_W=16).
module tb_control_sequencer;

  localparam int PcW = 6;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  control_sequencer_if #(.PC_W(6), .REG_AW(4), .INSTR_W(16)) bus ();

  control_sequencer #(
    .PC_W    (6),
    .REG_AW  (4),
    .INSTR_W (16),
    .IRQ_VEC (6'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {FS, MB, MD, RW, MM, MW, IL, halted}
  logic [10:0] ctrl;
  logic [11:0] fields;
  assign ctrl   = {bus.FS, bus.MB, bus.MD, bus.RW, bus.MM, bus.MW, bus.IL, bus.halted};
  assign fields = {bus.DR, bus.SA, bus.SB};

  localparam logic [10:0] FetchWord = 11'b0000_00000_10;
  localparam logic [10:0] HaltWord  = 11'b0000_00000_01;

  // Expected EXEC control word straight from the opcode table.
  function automatic logic [10:0] exec_word(input logic [3:0] op);
    if (op <= 4'h8) return {op, 7'b0010000};
    case (op)
      4'h9:    return {4'h2, 7'b1010000};
      4'hA:    return {4'h0, 7'b0111000};
      4'hB:    return {4'h0, 7'b0001100};
      default: return 11'd0;
    endcase
  endfunction

  // Expected PC after an instruction completes, using integer arithmetic.
  function automatic int next_pc(input int pc, input logic [15:0] ins, input logic n,
                                 input logic z, input logic [15:0] abus);
    int off;
    off = int'({ins[11:8], ins[3:0]});
    if (off >= 128) off = off - 256;
    case (ins[15:12])
      4'hC:    return z ? ((pc + 1 + off) & 63) : ((pc + 1) & 63);
      4'hD:    return n ? ((pc + 1 + off) & 63) : ((pc + 1) & 63);
      4'hE:    return int'(abus) & 63;
      4'hF:    return pc;
      default: return (pc + 1) & 63;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Fetch and execute one non-memory instruction (or a memory one with mem_ready=1).
  task automatic step_instr(input logic [15:0] ins, input logic [15:0] abus,
                            input logic [3:0] vcnz);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.A_bus = abus;
    {bus.V, bus.C, bus.N, bus.Z} = vcnz;
    bus.mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    bus.instruction = 16'hFFFF;
    bus.instr_valid = 1'b1;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.PC !== 6'd0) begin
      failures++; $display("FAIL reset_pc got=%0d want=0", bus.PC);
    end
    checks++;
    if (ctrl !== FetchWord) begin
      failures++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, FetchWord);
    end
    checks++;
    if (fields !== 12'h000) begin
      failures++; $display("FAIL reset_ir got=%h want=000", fields);
    end
  endtask

  task automatic test_alu;
    apply_reset();
    checks++;
    if (bus.IL !== 1'b1) begin
      failures++; $display("FAIL alu_fetch_il got=%b want=1", bus.IL);
    end
    bus.instruction = 16'h3123;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.FS !== 4'h3 || bus.RW !== 1'b1 || bus.MB !== 1'b0 || bus.IL !== 1'b0) begin
      failures++;
      $display("FAIL alu_exec got FS=%h RW=%b MB=%b IL=%b want FS=3 RW=1 MB=0 IL=0",
               bus.FS, bus.RW, bus.MB, bus.IL);
    end
    checks++;
    if (bus.PC !== 6'd0) begin
      failures++; $display("FAIL alu_pc_exec got=%0d want=0", bus.PC);
    end
    tick();
    checks++;
    if (bus.PC !== 6'd1 || ctrl !== FetchWord) begin
      failures++; $display("FAIL alu_pc_next got pc=%0d ctrl=%b want pc=1 ctrl=%b",
                           bus.PC, ctrl, FetchWord);
    end
  endtask

  task automatic test_fetch_stall;
    apply_reset();
    bus.instruction = 16'h1ABC;
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.IL !== 1'b1 || bus.PC !== 6'd0 || fields !== 12'h000) begin
        failures++; $display("FAIL stall_cycle%0d got il=%b pc=%0d ir=%h want il=1 pc=0 ir=000",
                             i, bus.IL, bus.PC, fields);
      end
    end
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    checks++;
    if (fields !== 12'hABC || ctrl !== exec_word(4'h1)) begin
      failures++; $display("FAIL stall_load got ir=%h ctrl=%b want ir=abc ctrl=%b",
                           fields, ctrl, exec_word(4'h1));
    end
  endtask

  task automatic test_ld_wait;
    logic ready_seq [3] = '{1'b0, 1'b0, 1'b1};
    apply_reset();
    bus.instruction = 16'hA123;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.MM !== 1'b1 || bus.MD !== 1'b1 || bus.RW !== 1'b1 || bus.PC !== 6'd0) begin
        failures++; $display("FAIL ld_wait%0d got MM=%b MD=%b RW=%b pc=%0d want 1 1 1 pc=0",
                             i, bus.MM, bus.MD, bus.RW, bus.PC);
      end
      bus.mem_ready = ready_seq[i];
      tick();
    end
    checks++;
    if (bus.PC !== 6'd1 || ctrl !== FetchWord) begin
      failures++; $display("FAIL ld_done got pc=%0d ctrl=%b want pc=1 ctrl=%b",
                           bus.PC, ctrl, FetchWord);
    end
    // Reset in the middle of a store wait abandons it.
    bus.instruction = 16'hB000;
    bus.instr_valid = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.instr_valid = 1'b0;
    tick();
    checks++;
    if (bus.MW !== 1'b1 || bus.MM !== 1'b1 || bus.RW !== 1'b0) begin
      failures++; $display("FAIL st_wait got MW=%b MM=%b RW=%b want 1 1 0", bus.MW, bus.MM, bus.RW);
    end
    bus.mem_ready = 1'b1;
    bus.instr_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.MW !== 1'b0 || bus.PC !== 6'd0 || bus.IL !== 1'b1) begin
      failures++; $display("FAIL st_reset got MW=%b pc=%0d IL=%b want 0 0 1", bus.MW, bus.PC, bus.IL);
    end
  endtask

  task automatic test_branch;
    // start pc, instruction, {V,C,N,Z}, expected pc
    int          starts [6] = '{5, 5, 63, 10, 10, 2};
    logic [15:0] instrs [6] = '{16'hCF0E, 16'hCF0E, 16'hC000, 16'hDF0E, 16'hCF0E, 16'hC705};
    logic [3:0]  flags  [6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
    int          expect_pc [6] = '{4, 6, 0, 9, 11, 56};
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      step_instr(16'hE000, 16'(starts[i]), 4'b0000);
      step_instr(instrs[i], 16'h0000, flags[i]);
      checks++;
      if (int'(bus.PC) != expect_pc[i]) begin
        failures++; $display("FAIL branch%0d got=%0d want=%0d", i, bus.PC, expect_pc[i]);
      end
    end
  endtask

  task automatic test_jmp;
    apply_reset();
    step_instr(16'hE000, 16'h0027, 4'b0000);
    checks++;
    if (bus.PC !== 6'd39) begin
      failures++; $display("FAIL jmp got=%0d want=39", bus.PC);
    end
    step_instr(16'hE123, 16'hFFC5, 4'b1111);
    checks++;
    if (bus.PC !== 6'd5) begin
      failures++; $display("FAIL jmp_trunc got=%0d want=5", bus.PC);
    end
  endtask

  task automatic test_halt;
    apply_reset();
    step_instr(16'h0000, 16'h0000, 4'b0000);
    step_instr(16'hF000, 16'h0000, 4'b0000);
    bus.instruction = 16'h3000;
    for (int i = 0; i < 10; i++) begin
      bus.instr_valid = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      checks++;
      if (ctrl !== HaltWord || bus.PC !== 6'd1) begin
        failures++; $display("FAIL halt%0d got ctrl=%b pc=%0d want ctrl=%b pc=1",
                             i, ctrl, bus.PC, HaltWord);
      end
      tick();
    end
    bus.instr_valid = 1'b0;
    apply_reset();
    checks++;
    if (bus.halted !== 1'b0 || bus.PC !== 6'd0) begin
      failures++; $display("FAIL halt_exit got halted=%b pc=%0d want 0 0", bus.halted, bus.PC);
    end
  endtask

  task automatic test_random;
    int          mpc;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [15:0] abus;
    apply_reset();
    mpc = 0;
    for (int k = 0; k < 80; k++) begin
      op = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      ins = {op, 12'($urandom)};
      checks++;
      if (ctrl !== FetchWord || int'(bus.PC) != mpc) begin
        failures++; $display("FAIL rnd_fetch%0d got ctrl=%b pc=%0d want ctrl=%b pc=%0d",
                             k, ctrl, bus.PC, FetchWord, mpc);
      end
      repeat ($urandom_range(0, 2)) begin
        bus.instr_valid = 1'b0;
        bus.instruction = 16'($urandom);
        tick();
      end
      bus.instruction = ins;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      bus.instruction = 16'($urandom);
      checks++;
      if (ctrl !== exec_word(op) || fields !== ins[11:0]) begin
        failures++; $display("FAIL rnd_exec%0d op=%h got ctrl=%b ir=%h want ctrl=%b ir=%h",
                             k, op, ctrl, fields, exec_word(op), ins[11:0]);
      end
      if (op == 4'hA || op == 4'hB) begin
        repeat ($urandom_range(0, 2)) begin
          bus.mem_ready = 1'b0;
          {bus.V, bus.C, bus.N, bus.Z} = 4'($urandom);
          tick();
          checks++;
          if (ctrl !== exec_word(op) || int'(bus.PC) != mpc) begin
            failures++; $display("FAIL rnd_wait%0d got ctrl=%b pc=%0d want ctrl=%b pc=%0d",
                                 k, ctrl, bus.PC, exec_word(op), mpc);
          end
        end
        bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      abus = 16'($urandom);
      bus.A_bus = abus;
      {bus.V, bus.C, bus.N, bus.Z} = 4'($urandom);
      mpc = next_pc(mpc, ins, bus.N, bus.Z, abus);
      tick();
      checks++;
      if (int'(bus.PC) != mpc) begin
        failures++; $display("FAIL rnd_pc%0d op=%h got=%0d want=%0d", k, op, bus.PC, mpc);
      end
      if (op == 4'hF) begin
        checks++;
        if (ctrl !== HaltWord) begin
          failures++; $display("FAIL rnd_halt%0d got=%b want=%b", k, ctrl, HaltWord);
        end
        apply_reset();
        mpc = 0;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.A_bus = '0;
    bus.V = 1'b0;
    bus.C = 1'b0;
    bus.N = 1'b0;
    bus.Z = 1'b0;
    bus.mem_ready = 1'b0;
`ifdef CU_IRQ_EN
    bus.irq = 1'b0;
`endif
    test_reset();
    test_alu();
    test_fetch_stall();
    test_ld_wait();
    test_branch();
    test_jmp();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the 16-bit teaching CPU. It holds the program counter, instruction register and the FETCH/EXEC/HALT state machine, and emits the datapath control word each cycle. It generalises PC width, register-address width and instruction width. It adds an instruction-fetch valid handshake, a data-memory ready handshake, flag-conditioned relative branches, a HALT state and an optional interrupt vector. It sits between the instruction ROM, the register file/ALU datapath and data memory.

## Interface
- PC_W, 6, program counter width
- REG_AW, 4, register address width (DR/SA/SB fields)
- INSTR_W, 16, instruction width; must satisfy INSTR_W >= 4 + 3*REG_AW
- IRQ_VEC, 0, interrupt vector PC value (PC_W bits; used only with CU_IRQ_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction  in  INSTR_W  word from ROM at address PC
- instr_valid  in  1  instruction is valid this cycle
- A_bus  in  16  register-file A data; jump target / memory address
- V, C, N, Z  in  1 each  ALU flags from the current cycle
- mem_ready  in  1  data memory completes the LD/ST this cycle
- irq  in  1  interrupt request, level (CU_IRQ_EN only)
- PC  out  PC_W  current program counter
- DR, SA, SB  out  REG_AW each  IR fields
- FS  out  4  ALU function select
- MB, MD, RW, MM, MW  out  1 each  control word bits
- IL  out  1  instruction load strobe
- halted  out  1  sequencer is in HALT

## Operation
- Fields are opcode = IR[INSTR_W-1 -: 4]. DR, SA and SB are consecutive REG_AW fields below the opcode, with SB lowest. Remaining low bits are ignored.
- FETCH: IL=1 and all control bits are 0. If instr_valid=1, IR loads on the edge and the state moves to EXEC. Otherwise the state stays in FETCH.
- EXEC: IL=0. The control word decodes from the IR opcode:
  - 0x0–0x8 ALU: FS=opcode, RW=1, MB=0.
  - 0x9 ALU-immediate: FS=0x2, MB=1, RW=1.
  - 0xA LD: MM=1, MD=1, RW=1, FS=0.
  - 0xB ST: MM=1, MW=1, RW=0.
  - 0xC BRZ and 0xD BRN: no writes. The branch is taken if Z (for BRZ) or N (for BRN) is 1.
  - 0xE JMP: PC<=A_bus[PC_W-1:0].
  - 0xF HALT: the state moves to HALT.
- LD and ST hold EXEC with an unchanged control word until mem_ready=1. RW and MW are asserted every cycle of the wait. The datapath must qualify the register write with mem_ready.
- PC update when EXEC completes:
  - Default: PC+1.
  - Taken branch: PC+1+sext({DR,SB}), where the offset is 2*REG_AW bits, two's complement.
  - JMP: A_bus target.
  - All PC arithmetic is modulo 2^PC_W. 2^PC_W−1 plus 1 wraps to 0.
- HALT: halted=1, IL=0, all control bits are 0 and PC is frozen. The state exits only by reset, or by irq when CU_IRQ_EN is defined.
- Undefined field values are not possible because the opcode is exhaustive over 4 bits.

## Timing
- Reset values: PC=0, IR=0, state=FETCH, IL=1 (combinational from FETCH), FS=0, all control bits 0, halted=0.
- Reset takes priority over every other event, including a pending mem_ready, instr_valid or irq in the same cycle.
- Minimum latency is 2 cycles per instruction: FETCH with instr_valid, then one EXEC cycle. LD/ST add one cycle per mem_ready=0 cycle.
- Control outputs are combinational from the state and IR. PC, IR and state are registered.
- PC changes only on the edge that ends EXEC, so ROM address PC is stable throughout FETCH.
- Flags are sampled during the final EXEC cycle of the branch.
- Reset during an LD/ST wait abandons the access. MW deasserts in the cycle after the reset edge.

## Configuration
- CU_IRQ_EN defined:
  - At the edge ending EXEC, if irq=1 the saved return register epc loads the would-be next PC and PC loads IRQ_VEC. IRQ_VEC supersedes branch and jump targets.
  - irq=1 in HALT also vectors to IRQ_VEC and moves the state to FETCH.
  - Opcode 0xF with DR all-ones is RETI: PC<=epc, no halt.
  - Interrupts are masked from vector entry until RETI completes.
  - epc resets to 0.
- CU_IRQ_EN undefined: the irq port, epc and the RETI decode are absent. 0xF always halts.

## Test plan
- Reset then ALU opcode 0x3 with instr_valid=1:
  - FETCH cycle shows IL=1.
  - EXEC shows FS=3, RW=1, MB=0.
  - PC goes 0→1 after 2 cycles.
- instr_valid held low for 3 cycles: state stays in FETCH, IL=1, PC=0, IR unchanged. IR loads on the first valid cycle.
- LD with mem_ready low for 2 cycles: MM=MD=RW=1 for 3 EXEC cycles, and PC increments only after mem_ready=1.
- BRZ at PC=5 with {DR,SB}=0xFE (−2):
  - Z=1 gives PC=4.
  - Z=0 gives PC=6.
  - At PC=63 with offset 0, the branch wraps to 0.
- JMP with A_bus=0x0027 → PC=39.
- HALT: halted=1 and PC is frozen for 10 cycles.
  - With CU_IRQ_EN, irq=1 gives PC=IRQ_VEC, epc=HALT PC+1, and RETI returns there.
